// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: arbiter sequencer
// states, transmitter bit-engine states and default sizing.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int DEFAULT_MAX_BURST = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        NEXT
    } arb_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START_BIT,
        TX_DATA_BITS,
        TX_STOP_BIT
    } tx_state_t;

    // Burst counter increment that sticks at the limit instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] limit);
        return (cnt >= limit) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus transmitter load/done strobes and grant status,
// bundled so the arbiter and its environment share one port list.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      grant_active;
    logic [ID_W-1:0]           grant_id;

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, grant_active, grant_id
    );

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, grant_active, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid index strictly after
// last_grant_i, wrapping, with last_grant_i itself checked last.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [$clog2(NUM_REQ)-1:0] winner_o,
    output logic                       any_valid_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;

    // NOTE: every output gets a default before the loop so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = '0;
        // Walk from the farthest offset down so the nearest valid wins last.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = ID_W'((int'(last_grant_i) + off) % NUM_REQ);
            if (valid_i[idx]) begin
                winner_o    = idx;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between NUM_REQ requesters: round-robin
// grant, per-byte load/start/wait sequencing, burst-limited ownership.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int         ID_W        = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    arb_state_t         state_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    last_grant_q;
    logic               grant_active_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic               tx_start_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic               last_q;
    logic [7:0]         burst_cnt_q;

    logic [ID_W-1:0]    pick_id;
    logic               any_valid;
    logic               release_d;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .valid_i     (bus.req_valid),
        .last_grant_i(last_grant_q),
        .winner_o    (pick_id),
        .any_valid_o (any_valid)
    );

    // Ownership ends on the last byte, at the burst cap, or when the owner goes quiet.
    assign release_d = last_q || (burst_cnt_q == BURST_LIMIT) || !bus.req_valid[grant_id_q];

    // NOTE: all state and outputs are registers updated with non-blocking
    // assignments; strobes default low each cycle and are raised on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
            grant_active_q <= 1'b0;
            req_ready_q    <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            last_q         <= 1'b0;
            burst_cnt_q    <= '0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_id_q     <= pick_id;
                        grant_active_q <= 1'b1;
                        burst_cnt_q    <= '0;
                        req_ready_q    <= NUM_REQ'(1) << pick_id;
                        state_q        <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data_q  <= bus.req_data[int'(grant_id_q) * DATA_W +: DATA_W];
                    last_q     <= bus.req_last[grant_id_q];
                    tx_start_q <= 1'b1;
                    state_q    <= START;
                end
                START: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        burst_cnt_q <= sat_inc(burst_cnt_q, BURST_LIMIT);
                        state_q     <= NEXT;
                    end
                end
                NEXT: begin
                    if (release_d) begin
                        last_grant_q   <= grant_id_q;
                        grant_active_q <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        req_ready_q <= NUM_REQ'(1) << grant_id_q;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.grant_active = grant_active_q;
    assign bus.grant_id     = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART byte transmitter between NUM_REQ independent requesters. Each requester offers bytes over a valid/ready handshake. The arbiter grants one requester, moves its bytes one at a time into the transmitter, and waits for each frame to finish before loading the next. A grant is held for a burst (until the requester marks the last byte, stops offering, or hits MAX_BURST), then priority rotates.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width on the requester and transmitter sides
MAX_BURST, 16, maximum bytes sent per grant before forced rotation (1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  per-requester last-byte-of-burst flag, qualified by req_valid
req_ready  out  NUM_REQ  one-hot byte accept strobe
tx_start  out  1  one-cycle pulse: transmitter loads tx_data
tx_data  out  DATA_W  byte presented to the transmitter, stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse from the transmitter when the stop bit completes
grant_active  out  1  a requester currently owns the transmitter
grant_id  out  $clog2(NUM_REQ)  index of the owning requester; valid while grant_active

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - all outputs 0; FSM goes to IDLE; burst_cnt 0.
  - Round-robin pointer is set so requester 0 has highest priority on the first arbitration.
  - Reset asserted mid-frame abandons the byte; any late tx_done is ignored because the FSM is in IDLE.
- Requester rule: once req_valid[i] is high, it stays high with req_data and req_last stable until req_ready[i] pulses. Violations are a requester error; the arbiter does not check for them.
- FSM states:
  - IDLE: if any req_valid, pick the first valid index searching upward (with wrap) from last_grant+1. Register grant_id, set grant_active, clear burst_cnt, go to LOAD. Otherwise stay.
  - LOAD: pulse req_ready[grant_id] for exactly one cycle. Capture req_data into tx_data and req_last into last_q. Go to START.
  - START: tx_start=1 for one cycle. Go to WAIT_DONE.
  - WAIT_DONE: hold tx_data. On tx_done, burst_cnt+1 and go to NEXT.
  - NEXT (one cycle): release when last_q==1, when burst_cnt==MAX_BURST, or when req_valid[grant_id]==0. Release means: last_grant<=grant_id, grant_active<=0, go to IDLE. Otherwise go to LOAD (same requester).
- Latency:
  - req_valid rising in IDLE at edge N: req_ready at N+1, tx_start at N+2.
  - tx_done at edge M with the burst continuing: req_ready at M+2, tx_start at M+3.
- tx_done is ignored in every state except WAIT_DONE. A tx_done in the same cycle as tx_start is not possible by construction.
- burst_cnt is 8 bits, saturates at MAX_BURST, and never wraps.
- Requesters that are not granted see req_ready low at all times.
- Only the granted requester's req_valid affects NEXT. Other valids arriving mid-burst wait for rotation.
- Fairness: with all requesters continuously valid and MAX_BURST=1, grants cycle 0,1,2,3,0,...

Decomposition:
- Shared package uart_pkg holds:
  - the arbiter state enum (IDLE, LOAD, START, WAIT_DONE, NEXT), kept alongside the transmitter's state type;
  - the constants UART_DATA_W=8 and the default MAX_BURST.
- One sub-module: rr_pick. It is combinational: inputs are the valid vector and last_grant; outputs are the winner index and an any-valid flag. The round-robin search is isolated there for separate unit test.

Test Plan:
1. Single requester: req_valid[2]=1, data 0x41, last=1 at edge 10 → req_ready[2] at 11; tx_start at 12 with tx_data=0x41; tx_done at 50 → grant_active low at 52; grant_id=2 during the burst.
2. Burst continuation: requester 1 sends 0x10, 0x11, 0x12 with last on 0x12 → three tx_start pulses, each 3 cycles after the preceding tx_done. No other grant occurs, even though req_valid[0] is high throughout.
3. Round robin: all 4 continuously valid, each byte last=1 → grant order 0,1,2,3,0. Each requester receives exactly 2 req_ready pulses over 8 frames.
4. MAX_BURST=4, requester 3 streaming without last, requester 0 valid → 4 bytes from requester 3, then grant moves to 0.
5. Reset mid-frame: rst at a clk edge while in WAIT_DONE with tx_data=0x7E → next cycle all outputs 0. A following tx_done pulse causes no req_ready. Fresh arbitration picks requester 0 first.
6. Early release: requester 1 drops req_valid after its first non-last byte → release in NEXT; a pending requester 2 is granted 1 cycle later.
